msrv32_iadder_arbiter: RTL
==========================

// Module: msrv32_iadder_arbiter
// PURPOSE
//  Shares one msrv32_immediate_adder between two requesters:
//   - port 0: branch/jump target unit (PC-relative or JALR targets).
//   - port 1: load/store unit (rs1 + offset).
//  Valid/ready on each request port. One registered result slot with its own
//  valid/ready handshake. Result carries requester id and a misalignment flag.
// PARAMETERS
//  WIDTH       32  address/operand width
//  FIXED_PRIO  0   0 = round-robin; 1 = port 0 always wins a tie
// PORTS
//  ms_riscv32_mp_clk_in  in   1      clock; all state on rising edge
//  ms_riscv32_mp_rst_in  in   1      synchronous, active-high reset
//  flush_in              in   1      drop held result, block new grants this cycle
//  reqN_valid_in         in   1      N=0,1: request present
//  reqN_ready_out        out  1      N=0,1: request accepted this cycle
//  reqN_src_in           in   1      N=0,1: 1 = rs1 + imm, 0 = pc + imm
//  reqN_pc_in            in   WIDTH  N=0,1: pc operand
//  reqN_rs1_in           in   WIDTH  N=0,1: rs1 operand
//  reqN_imm_in           in   WIDTH  N=0,1: sign-extended immediate
//  reqN_align_in         in   2      N=0,1: alignment mask checked on sum[1:0]
//  res_valid_out         out  1      result slot full
//  res_ready_in          in   1      consumer takes result this cycle
//  res_addr_out          out  WIDTH  registered sum
//  res_id_out            out  1      requester that produced res_addr_out
//  res_misaligned_out    out  1      |(sum[1:0] & align) of that request
// BEHAVIOUR
//  - Reset: res_valid_out=0, res_addr_out=0, res_id_out=0, res_misaligned_out=0,
//    round-robin pointer=0 (port 0 favoured first), state=EMPTY.
//  - FSM: EMPTY (slot free), FULL (slot holds result).
//  - Slot can accept when (EMPTY or (FULL and res_ready_in)) and !flush_in.
//    Transitions:
//      EMPTY -> FULL   on a grant.
//      FULL  -> EMPTY  on res_ready_in with no grant.
//      FULL  -> FULL   on res_ready_in with a grant (back-to-back, no bubble).
//  - Grant: one port per cycle, only when the slot can accept.
//      Single valid: that port is granted.
//      Both valid, FIXED_PRIO=1: port 0.
//      Both valid, FIXED_PRIO=0: port = pointer; pointer then moves to the
//      other port. Pointer updates only on a contended grant.
//  - reqN_ready_out=1 only for the granted port. It is combinational on
//    valids, slot state, res_ready_in and flush_in.
//  - Latency: request accepted in cycle N -> res_valid_out=1 in cycle N+1.
//    Throughput: one result/cycle while res_ready_in stays 1.
//  - Adder sources: the granted port's src/pc/rs1/imm; port 0 when idle.
//    The adder is combinational; the result is latched on the grant edge.
//  - Arithmetic: sum is modulo 2^WIDTH; carry out discarded.
//    0xFFFFFFFC + 8 = 0x00000004, with no flag.
//  - Misalignment: computed on the unmasked sum and reported, not blocked.
//    align=2'b00 disables the check.
//  - Requester rule: once valid is raised, hold valid and operands until
//    ready. The arbiter does not check this.
//  - Result stability: res_* stay stable while res_valid_out=1 and
//    res_ready_in=0.
//  - flush_in (beats a grant in the same cycle): next cycle res_valid_out=0;
//    the pointer is unchanged.
//  - Reset mid-operation: takes priority over flush and grants; the held
//    result is lost.
// STRUCTURE
//  - One instance of msrv32_immediate_adder.
//  - Grant/pointer logic and the result slot live in this module.
//  - Shared package msrv32_pkg: REQ_BR=1'b0, REQ_LSU=1'b1, IADDER_SRC_PC=1'b0,
//    IADDER_SRC_RS1=1'b1, ALIGN_WORD=2'b11, ALIGN_HALF=2'b01.
//  - No further sub-modules.
// TESTING
//  1. req0 only: pc=200, imm=20, src=0 -> next cycle res_addr=220, id=0,
//     misaligned=0.
//  2. req1 only: rs1=50, imm=30, src=1, align=11 -> res_addr=80, id=1,
//     misaligned=0. Same with imm=31 -> 81, misaligned=1.
//  3. Both valid for 4 cycles, res_ready=1, FIXED_PRIO=0 -> ids 0,1,0,1, one
//     per cycle. FIXED_PRIO=1 -> ids 0,0,0,0 and req1 never ready.
//  4. res_ready=0 with slot full -> both ready_out=0 and res_* frozen. Raise
//     res_ready -> the pending request's result appears the next cycle with
//     no bubble.
//  5. Wrap: src=1, rs1=0xFFFFFFFC, imm=8 -> res_addr=0x00000004.
//  6. flush_in with slot full and req0 valid -> next cycle res_valid=0 and
//     req0 not accepted. Reset asserted in FULL -> next cycle all outputs
//     at reset values.

Source files
------------

// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pkg
//  Description : Shared constants and helpers for the immediate-adder path.
//  Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

    localparam logic       REQ_BR         = 1'b0;
    localparam logic       REQ_LSU        = 1'b1;
    localparam logic       IADDER_SRC_PC  = 1'b0;
    localparam logic       IADDER_SRC_RS1 = 1'b1;
    localparam logic [1:0] ALIGN_WORD     = 2'b11;
    localparam logic [1:0] ALIGN_HALF     = 2'b01;

    // Any low address bit selected by the mask that is set marks a misaligned access.
    function automatic logic misaligned(input logic [1:0] lsb, input logic [1:0] align);
        return |(lsb & align);
    endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_immediate_adder.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_immediate_adder
//  Description : Combinational (pc | rs1) + imm, modulo 2^WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_immediate_adder
    import msrv32_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             i_src,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] w_base;

    assign w_base = (i_src == IADDER_SRC_RS1) ? i_rs1 : i_pc;
    assign o_sum  = w_base + i_imm;

endmodule
`default_nettype wire

// File: rtl/msrv32_iadder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_iadder_arbiter
//  Description : Shares one immediate adder between the branch unit (port 0)
//                and the LSU (port 1); one registered result slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_iadder_arbiter
    import msrv32_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FIXED_PRIO = 0
)(
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             flush_in,
    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic             req0_src_in,
    input  logic [WIDTH-1:0] req0_pc_in,
    input  logic [WIDTH-1:0] req0_rs1_in,
    input  logic [WIDTH-1:0] req0_imm_in,
    input  logic [1:0]       req0_align_in,
    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic             req1_src_in,
    input  logic [WIDTH-1:0] req1_pc_in,
    input  logic [WIDTH-1:0] req1_rs1_in,
    input  logic [WIDTH-1:0] req1_imm_in,
    input  logic [1:0]       req1_align_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] res_addr_out,
    output logic             res_id_out,
    output logic             res_misaligned_out
);

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]       r_state;
    logic             r_ptr;
    logic [WIDTH-1:0] r_res_addr;
    logic             r_res_id;
    logic             r_res_mis;

    logic             w_can_accept;
    logic             w_pick1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_contended;
    logic             w_src;
    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_rs1;
    logic [WIDTH-1:0] w_imm;
    logic [1:0]       w_align;
    logic [WIDTH-1:0] w_sum;

    assign w_can_accept = ((r_state == c_st_empty) || res_ready_in) && !flush_in;
    assign w_contended  = req0_valid_in && req1_valid_in;

    // w_pick1 decides which port wins only when both are requesting.
    generate
        if (FIXED_PRIO != 0) begin : g_fixed_prio
            assign w_pick1 = 1'b0;
        end else begin : g_round_robin
            assign w_pick1 = r_ptr;
        end
    endgenerate

    assign w_gnt0 = w_can_accept && req0_valid_in && (!req1_valid_in || !w_pick1);
    assign w_gnt1 = w_can_accept && req1_valid_in && (!req0_valid_in ||  w_pick1);

    assign req0_ready_out = w_gnt0;
    assign req1_ready_out = w_gnt1;

    // Operands follow the winner; port 0 drives the adder when nobody is granted.
    assign w_src   = w_gnt1 ? req1_src_in   : req0_src_in;
    assign w_pc    = w_gnt1 ? req1_pc_in    : req0_pc_in;
    assign w_rs1   = w_gnt1 ? req1_rs1_in   : req0_rs1_in;
    assign w_imm   = w_gnt1 ? req1_imm_in   : req0_imm_in;
    assign w_align = w_gnt1 ? req1_align_in : req0_align_in;

    msrv32_immediate_adder #(
        .WIDTH (WIDTH)
    ) u_iadder (
        .i_src (w_src),
        .i_pc  (w_pc),
        .i_rs1 (w_rs1),
        .i_imm (w_imm),
        .o_sum (w_sum)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state    <= c_st_empty;
            r_ptr      <= 1'b0;
            r_res_addr <= '0;
            r_res_id   <= 1'b0;
            r_res_mis  <= 1'b0;
        end else begin
            if (flush_in) begin
                r_state <= c_st_empty;
            end else if (w_gnt0 || w_gnt1) begin
                r_state    <= c_st_full;
                r_res_addr <= w_sum;
                r_res_id   <= w_gnt1 ? REQ_LSU : REQ_BR;
                r_res_mis  <= misaligned(w_sum[1:0], w_align);
            end else if ((r_state == c_st_full) && res_ready_in) begin
                r_state <= c_st_empty;
            end

            // A contended grant always goes to the pointed-at port, so toggling moves it away.
            if ((FIXED_PRIO == 0) && w_contended && (w_gnt0 || w_gnt1)) begin
                r_ptr <= ~r_ptr;
            end
        end
    end

    assign res_valid_out      = (r_state == c_st_full);
    assign res_addr_out       = r_res_addr;
    assign res_id_out         = r_res_id;
    assign res_misaligned_out = r_res_mis;

endmodule
`default_nettype wire
